// File: rtl/load_wb_stage.sv
// Writeback stage feeding the integer register file: retires ALU results in one cycle,
// waits for data-memory responses on loads, then aligns and sign/zero-extends the load data.
module load_wb_stage #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_result,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            write_enable,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,
  output logic            load_misaligned,
  output logic            load_illegal,
  output logic            load_timeout
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t            state_q;
  logic              we_q, mis_q, ill_q, to_q;
  logic [4:0]        waddr_q, rd_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        f3_q, lo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   load_data;
  logic              misaligned;
  logic              illegal;

  assign raw = mem_rsp_data >> {lo_q, 3'b000};

  always_comb begin
    load_data = raw;
    case (f3_q)
      3'b000:  load_data = {{(XLEN-8){raw[7]}},   raw[7:0]};
      3'b001:  load_data = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b010:  load_data = {{(XLEN-32){raw[31]}}, raw[31:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}},     raw[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}},    raw[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}},    raw[31:0]};
      default: load_data = raw;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (f3_q)
      3'b001, 3'b101: misaligned = lo_q[0];
      3'b010, 3'b110: misaligned = |lo_q[1:0];
      3'b011:         misaligned = |lo_q;
      default:        misaligned = 1'b0;
    endcase
  end

  assign illegal = (f3_q == 3'b111);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      we_q  <= 1'b0;
      mis_q <= 1'b0;
      ill_q <= 1'b0;
      to_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_is_load) begin
              rd_q    <= in_rd;
              f3_q    <= in_funct3;
              lo_q    <= in_addr_lo;
              cnt_q   <= '0;
              state_q <= LOAD_WAIT;
            end else begin
              we_q    <= (in_rd != 5'd0);
              waddr_q <= in_rd;
              wdata_q <= in_result;
            end
          end
        end
        LOAD_WAIT: begin
          // A response on the last timeout cycle still wins over the timeout.
          if (mem_rsp_valid) begin
            state_q <= IDLE;
            if (misaligned) begin
              mis_q <= 1'b1;
            end else if (illegal) begin
              ill_q <= 1'b1;
            end else begin
              we_q    <= (rd_q != 5'd0);
              waddr_q <= rd_q;
              wdata_q <= load_data;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            to_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign write_enable    = we_q;
  assign waddr           = waddr_q;
  assign wdata           = wdata_q;
  assign load_misaligned = mis_q;
  assign load_illegal    = ill_q;
  assign load_timeout    = to_q;

endmodule
